// File: rtl/handshake_word_packer.sv
// handshake_word_packer
//   Packs RATIO consecutive IN_WIDTH-bit input words into one OUT_WIDTH-bit
//   word. Input word k of a packed word lands in lane k, so the first word is
//   in the least-significant lane. A word is emitted when it is full or when
//   an input carries InputLast. Unwritten lanes of a partial word read as zero.
//
// Ports
//   clk, async_rst_n        clock, asynchronous active-low reset
//   clk_en                  clock enable; no transfer and no state change while low
//   InputREQ/ACK/Data/Last  upstream request/acknowledge word stream
//   OutputREQ/ACK           downstream handshake (FIFO write port)
//   OutputData              packed word, lane k = OutputData[k*IN_WIDTH +: IN_WIDTH]
//   OutputCount             number of valid lanes in OutputData (1..RATIO)
//   OutputLast              packed word closes a burst

// One lane register of the accumulator. When a write and a clear happen in
// the same cycle, the write wins, so a lane can be refilled on the cycle the
// previous word leaves.
module packerLane #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         async_rst_n,
  input  logic         clr,
  input  logic         wr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) q <= '0;
    else if (wr)      q <= d;
    else if (clr)     q <= '0;
  end
endmodule

module handshake_word_packer #(
  parameter  int IN_WIDTH  = 8,
  parameter  int RATIO     = 4,
  localparam int OUT_WIDTH = IN_WIDTH * RATIO,
  localparam int CNT_W     = $clog2(RATIO + 1)
) (
  input  logic                 clk,
  input  logic                 async_rst_n,
  input  logic                 clk_en,
  input  logic                 InputREQ,
  output logic                 InputACK,
  input  logic [IN_WIDTH-1:0]  InputData,
  input  logic                 InputLast,
  output logic                 OutputREQ,
  input  logic                 OutputACK,
  output logic [OUT_WIDTH-1:0] OutputData,
  output logic [CNT_W-1:0]     OutputCount,
  output logic                 OutputLast
);

  typedef enum logic {FILL, HOLD} state_t;

  state_t                           state, stateNext;
  logic   [CNT_W-1:0]               cnt, cntNext;
  logic                             lastNext;
  logic                             inXfer, outXfer;
  logic   [RATIO-1:0][IN_WIDTH-1:0] laneQ;

  // In HOLD an input is only taken when the held word leaves in the same
  // cycle; reset gating keeps ACK low while reset is asserted.
  assign InputACK = async_rst_n & clk_en & ((state == FILL) | OutputACK);
  assign inXfer   = InputREQ & InputACK;
  assign outXfer  = clk_en & (state == HOLD) & OutputACK;

  assign OutputREQ   = (state == HOLD);
  assign OutputCount = cnt;
  assign OutputData  = laneQ;

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    lastNext  = OutputLast;
    if (outXfer && inXfer) begin
      // Word leaves and the incoming word starts a fresh one in lane 0.
      cntNext   = CNT_W'(1);
      lastNext  = InputLast;
      stateNext = (InputLast || RATIO == 1) ? HOLD : FILL;
    end else if (outXfer) begin
      cntNext   = '0;
      lastNext  = 1'b0;
      stateNext = FILL;
    end else if (inXfer) begin
      cntNext  = cnt + 1'b1;
      lastNext = InputLast;
      if (cntNext == CNT_W'(RATIO) || InputLast) stateNext = HOLD;
    end
  end

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      state      <= FILL;
      cnt        <= '0;
      OutputLast <= 1'b0;
    end else begin
      state      <= stateNext;
      cnt        <= cntNext;
      OutputLast <= lastNext;
    end
  end

  // Lane k is written by the k-th input of a word; when the previous word is
  // leaving, the new input always goes to lane 0 and every other lane clears.
  for (genvar k = 0; k < RATIO; k++) begin : gLane
    logic laneWr;
    assign laneWr = inXfer & (outXfer ? (k == 0) : (cnt == CNT_W'(k)));

    packerLane #(.W(IN_WIDTH)) uLane (
      .clk         (clk),
      .async_rst_n (async_rst_n),
      .clr         (outXfer),
      .wr          (laneWr),
      .d           (InputData),
      .q           (laneQ[k])
    );
  end

endmodule
